// File: rtl/vx_stream_fair_mux.sv
// N-to-1 valid/ready stream mux with batch-fair arbitration feeding a
// 2-entry skid buffer, so upstream ready never depends on downstream ready.
module vx_stream_fair_mux #(
    parameter int NUM_INPUTS = 4,
    parameter int DATAW      = 32,
    parameter int SELW       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS-1:0]       valid_in,
    input  logic [NUM_INPUTS*DATAW-1:0] data_in,
    output logic [NUM_INPUTS-1:0]       ready_in,
    output logic                        valid_out,
    output logic [DATAW-1:0]            data_out,
    output logic [SELW-1:0]             sel_out,
    input  logic                        ready_out
);

    logic [NUM_INPUTS-1:0] batch;
    logic [NUM_INPUTS-1:0] masked;
    logic [NUM_INPUTS-1:0] qual;
    logic [NUM_INPUTS-1:0] grant_onehot;
    logic [SELW-1:0]       grant_idx;
    logic [DATAW-1:0]      grant_data;
    logic                  grant_found;

    logic [1:0]            count_q, count_d;
    logic [DATAW-1:0]      head_data_q, head_data_d;
    logic [DATAW-1:0]      tail_data_q, tail_data_d;
    logic [SELW-1:0]       head_sel_q, head_sel_d;
    logic [SELW-1:0]       tail_sel_q, tail_sel_d;

    logic                  full;
    logic                  push;
    logic                  pop;

    // Serve the pending snapshot first; refill from live requests once it is exhausted.
    always_comb begin
        masked       = batch & valid_in;
        qual         = (|masked) ? masked : valid_in;
        grant_onehot = '0;
        grant_idx    = '0;
        grant_data   = '0;
        grant_found  = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (qual[i] && !grant_found) begin
                grant_found     = 1'b1;
                grant_onehot[i] = 1'b1;
                grant_idx       = SELW'(i);
                grant_data      = data_in[i*DATAW +: DATAW];
            end
        end
    end

    assign full      = (count_q == 2'd2);
    assign ready_in  = grant_onehot & {NUM_INPUTS{~full}};
    assign push      = |(valid_in & ready_in);
    assign pop       = (count_q != 2'd0) & ready_out;

    assign valid_out = (count_q != 2'd0);
    assign data_out  = head_data_q;
    assign sel_out   = head_sel_q;

    generate
        if (NUM_INPUTS > 1) begin : g_batch
            logic [NUM_INPUTS-1:0] batch_q, batch_d;

            always_comb begin
                batch_d = batch_q;
                if (push) begin
                    batch_d = qual & ~grant_onehot;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    batch_q <= '0;
                end else begin
                    batch_q <= batch_d;
                end
            end

            assign batch = batch_q;
        end else begin : g_no_batch
            assign batch = '0;
        end
    endgenerate

    // On simultaneous push and pop the tail entry (if any) slides to the head.
    always_comb begin
        count_d     = count_q;
        head_data_d = head_data_q;
        head_sel_d  = head_sel_q;
        tail_data_d = tail_data_q;
        tail_sel_d  = tail_sel_q;
        case ({push, pop})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    head_data_d = grant_data;
                    head_sel_d  = grant_idx;
                end else begin
                    tail_data_d = grant_data;
                    tail_sel_d  = grant_idx;
                end
            end
            2'b01: begin
                count_d     = count_q - 2'd1;
                head_data_d = tail_data_q;
                head_sel_d  = tail_sel_q;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_data_d = grant_data;
                    head_sel_d  = grant_idx;
                end else begin
                    head_data_d = tail_data_q;
                    head_sel_d  = tail_sel_q;
                    tail_data_d = grant_data;
                    tail_sel_d  = grant_idx;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Payload storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        head_data_q <= head_data_d;
        head_sel_q  <= head_sel_d;
        tail_data_q <= tail_data_d;
        tail_sel_q  <= tail_sel_d;
    end

endmodule

// File: tb/tb_vx_stream_fair_mux.sv
// Self-checking bench for vx_stream_fair_mux: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_vx_stream_fair_mux;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct {
        int          sel;
        logic [31:0] data;
    } entry_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     valid_in = '0;
    logic [N*W-1:0]   data_in = '0;
    logic [N-1:0]     ready_in;
    logic             valid_out;
    logic [W-1:0]     data_out;
    logic [1:0]       sel_out;
    logic             ready_out = 1'b0;

    int numChecks = 0;
    int numFails  = 0;

    int     pend[$];
    entry_t skid[$];
    int     outLog[$];
    int     lastXfer;

    logic          obsValid;
    logic [W-1:0]  obsData;
    logic [1:0]    obsSel;
    logic [N-1:0]  obsReady;

    vx_stream_fair_mux #(.NUM_INPUTS(N), .DATAW(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sel_out   (sel_out),
        .ready_out (ready_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        pend.delete();
        skid.delete();
    endtask

    // One cycle: drive at negedge, check against the model, advance model at posedge.
    task automatic applyStimulus(input logic [N-1:0] vin, input logic [N*W-1:0] din, input logic rout);
        int          ql[$];
        int          g;
        logic [N-1:0] expReady;
        entry_t      e;
        @(negedge clk);
        valid_in  = vin;
        data_in   = din;
        ready_out = rout;
        #1;
        foreach (pend[k]) if (vin[pend[k]]) ql.push_back(pend[k]);
        if (ql.size() == 0) begin
            for (int i = 0; i < N; i++) if (vin[i]) ql.push_back(i);
        end
        g = (ql.size() != 0) ? ql[0] : -1;
        expReady = '0;
        if (g >= 0 && skid.size() < 2) expReady[g] = 1'b1;
        obsValid = valid_out;
        obsData  = data_out;
        obsSel   = sel_out;
        obsReady = ready_in;
        checkOutput("ready_in", 64'(ready_in), 64'(expReady));
        checkOutput("valid_out", 64'(valid_out), 64'(skid.size() != 0));
        if (skid.size() != 0) begin
            checkOutput("data_out", 64'(data_out), 64'(skid[0].data));
            checkOutput("sel_out", 64'(sel_out), 64'(skid[0].sel));
        end
        if (valid_out && rout) outLog.push_back(int'(sel_out));
        @(posedge clk);
        if (skid.size() != 0 && rout) void'(skid.pop_front());
        lastXfer = -1;
        if (expReady != '0) begin
            lastXfer = g;
            e.sel  = g;
            e.data = din[g*W +: W];
            skid.push_back(e);
            pend.delete();
            for (int k = 1; k < ql.size(); k++) pend.push_back(ql[k]);
        end
    endtask

    // Asserts reset between clock edges and checks the asynchronous clear.
    task automatic pulseReset();
        valid_in  = '0;
        ready_out = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_valid_out", 64'(valid_out), 64'd0);
        checkOutput("reset_ready_in", 64'(ready_in), 64'd0);
        clearModel();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic checkLog(input string tag, input int exp[$]);
        checkOutput({tag, "_len"}, 64'(outLog.size()), 64'(exp.size()));
        for (int k = 0; k < exp.size() && k < outLog.size(); k++)
            checkOutput(tag, 64'(outLog[k]), 64'(exp[k]));
        outLog.delete();
    endtask

    function automatic logic [N*W-1:0] packData(input logic [31:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    initial begin
        logic [N-1:0]   holdV;
        logic [W-1:0]   holdD [N];
        logic [N*W-1:0] din;
        logic [N-1:0]   vin;
        int             expSeq[$];

        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Buffer one entry, then reset it away asynchronously.
        applyStimulus(4'b0001, packData(32'h1234, 0, 0, 0), 1'b0);
        applyStimulus(4'b0000, '0, 1'b0);
        pulseReset();

        // Single request on input 2.
        applyStimulus(4'b0100, packData(0, 0, 32'hA5, 0), 1'b1);
        checkOutput("first_ready_in", 64'(obsReady), 64'h4);
        applyStimulus(4'b0000, '0, 1'b1);
        checkOutput("first_valid", 64'(obsValid), 64'd1);
        checkOutput("first_data", 64'(obsData), 64'hA5);
        checkOutput("first_sel", 64'(obsSel), 64'd2);
        applyStimulus(4'b0000, '0, 1'b1);
        outLog.delete();

        // Fairness: all valid, then input 1 drops for the next round.
        repeat (8) applyStimulus(4'b1111, packData(32'h10, 32'h11, 32'h12, 32'h13), 1'b1);
        repeat (3) applyStimulus(4'b1101, packData(32'h20, 32'h21, 32'h22, 32'h23), 1'b1);
        applyStimulus(4'b0000, '0, 1'b1);
        applyStimulus(4'b0000, '0, 1'b1);
        expSeq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3};
        checkLog("fair_seq", expSeq);

        // Late arrival of input 0 must not preempt batch member 2.
        applyStimulus(4'b0110, packData(0, 32'hB1, 32'hB2, 0), 1'b1);
        applyStimulus(4'b0101, packData(32'hB0, 0, 32'hB2, 0), 1'b1);
        applyStimulus(4'b0001, packData(32'hB0, 0, 0, 0), 1'b1);
        repeat (2) applyStimulus(4'b0000, '0, 1'b1);
        expSeq = '{1, 2, 0};
        checkLog("late_seq", expSeq);

        // Backpressure: only two transfers fit.
        din = packData(0, 32'h11110001, 0, 32'h33330003);
        applyStimulus(4'b1010, din, 1'b0);
        applyStimulus(4'b1010, din, 1'b0);
        applyStimulus(4'b1010, din, 1'b0);
        checkOutput("bp_ready_zero", 64'(obsReady), 64'd0);
        checkOutput("bp_hold_data", 64'(obsData), 64'h11110001);
        applyStimulus(4'b0000, '0, 1'b1);
        applyStimulus(4'b0000, '0, 1'b1);
        applyStimulus(4'b0000, '0, 1'b1);
        checkOutput("bp_drained", 64'(obsValid), 64'd0);
        expSeq = '{1, 3};
        checkLog("bp_seq", expSeq);

        // Alternating downstream ready under full load.
        for (int c = 0; c < 20; c++)
            applyStimulus(4'b1111, packData($urandom, $urandom, $urandom, $urandom), 1'(c % 2 == 0));
        repeat (3) applyStimulus(4'b0000, '0, 1'b1);
        outLog.delete();

        // Reset with a full buffer and a partial batch, then restart from index 0.
        repeat (2) applyStimulus(4'b1111, packData(1, 2, 3, 4), 1'b0);
        checkOutput("pre_reset_full", 64'(skid.size()), 64'd2);
        pulseReset();
        outLog.delete();
        repeat (4) applyStimulus(4'b1111, packData(5, 6, 7, 8), 1'b1);
        applyStimulus(4'b0000, '0, 1'b1);
        expSeq = '{0, 1, 2, 3};
        checkLog("post_reset_seq", expSeq);

        // Randomized traffic, occasionally dropping a waiting request.
        holdV = '0;
        for (int i = 0; i < N; i++) holdD[i] = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!holdV[i] && ($urandom % 3 == 0)) begin
                    holdV[i] = 1'b1;
                    holdD[i] = $urandom;
                end else if (holdV[i] && ($urandom % 40 == 0)) begin
                    holdV[i] = 1'b0;
                end
            end
            vin = holdV;
            din = packData(holdD[0], holdD[1], holdD[2], holdD[3]);
            applyStimulus(vin, din, 1'($urandom % 4 != 0));
            if (lastXfer >= 0) holdV[lastXfer] = 1'b0;
        end
        repeat (3) applyStimulus(4'b0000, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
